shift_seq_ctrl: RTL
===================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bits per word, legal range 2..32.
REQ-002 Parameter DEPTH, default 4: number of stages in the downstream serial-in serial-out register, legal range 1..16.
REQ-003 Port i_clk, input, 1: sole clock; all controller flops on rising edge.
REQ-004 Port i_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port i_valid, input, 1: upstream word valid.
REQ-006 Port i_data, input, WIDTH: parallel word to serialize.
REQ-007 Port o_ready, output, 1: controller can accept a word this cycle.
REQ-008 Port i_abort, input, 1: synchronous abort of the current transfer.
REQ-009 Port o_sdata, output, 1: serial bit driven to the shift register D input.
REQ-010 Port o_shift_en, output, 1: shift enable / clock-gate enable for the shift register.
REQ-011 Port o_sframe, output, 1: high while o_sdata carries a valid data bit.
REQ-012 Port o_busy, output, 1: high in any state other than IDLE.
REQ-013 Port o_done, output, 1: one-cycle pulse when a transfer fully exits the shift register.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and FLUSH.
REQ-015 o_ready SHALL equal 1 only in IDLE; a word SHALL be accepted on a rising edge with i_valid=1 and o_ready=1.
REQ-016 On accept, the FSM SHALL move IDLE->SHIFT, capture i_data into an internal register and clear the bit counter.
REQ-017 In SHIFT, o_sframe=1 and o_shift_en=1; o_sdata SHALL present the data MSB-first, one bit per cycle, bit WIDTH-1 in the first SHIFT cycle.
REQ-018 SHIFT SHALL last exactly WIDTH cycles, then go to FLUSH.
REQ-019 In FLUSH, o_sframe=0, o_shift_en=1 and o_sdata=0; FLUSH SHALL last exactly DEPTH cycles, then go to IDLE.
REQ-020 o_done SHALL be 1 for exactly the first IDLE cycle after a completed FLUSH and 0 otherwise.
REQ-021 Total latency from the accept edge to the o_done pulse SHALL be WIDTH+DEPTH cycles.
REQ-022 In IDLE, o_sdata, o_sframe and o_shift_en SHALL be 0.
REQ-023 i_abort=1 in SHIFT or FLUSH SHALL force IDLE on the next edge with no o_done pulse; the captured word is discarded.
REQ-024 i_abort=1 in IDLE SHALL take priority over accept: no word is accepted.
REQ-025 i_valid while busy SHALL be ignored; i_data is not sampled.
REQ-026 The bit counter SHALL be $clog2(max(WIDTH,DEPTH)+1) bits wide and SHALL not wrap within a state.
REQ-027 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs.
REQ-028 Back-to-back transfers SHALL be separated by at least one IDLE cycle, the o_done/o_ready cycle.
REQ-029 The downstream register samples on the falling edge of i_clk, giving a half-cycle setup margin on o_sdata and o_shift_en.

Reset
REQ-030 When i_rst_n=0, the block SHALL asynchronously enter IDLE and clear the counter and data register.
REQ-031 During reset, o_ready=0 and o_sdata, o_sframe, o_shift_en, o_busy and o_done = 0.
REQ-032 o_ready SHALL rise in the first cycle after reset deassertion.
REQ-033 Reset during SHIFT or FLUSH SHALL abandon the transfer with no o_done pulse.

Structure
REQ-034 A shared package SHALL hold the state enumeration (IDLE, SHIFT, FLUSH) and the default WIDTH/DEPTH constants.
REQ-035 One sub-module, shift_bit_counter, SHALL provide the loadable, clearable down-counter used for both SHIFT and FLUSH.

Verification
REQ-036 WIDTH=8, DEPTH=4, accept 8'hA5 -> o_sdata 1,0,1,0,0,1,0,1 with o_sframe=1 for 8 cycles; 4 FLUSH cycles; o_done 12 cycles after the accept edge.
REQ-037 Model a 4-stage falling-edge shift register -> its output reproduces 1,0,1,0,0,1,0,1, delayed 4 cycles from o_sdata.
REQ-038 i_abort asserted in the 3rd SHIFT cycle -> IDLE next cycle, o_done never pulses, o_ready=1.
REQ-039 i_valid held high continuously with 8'hFF then 8'h00 -> the second word is accepted only in the IDLE cycle after o_done, and exactly two o_done pulses occur.
REQ-040 i_rst_n pulsed low mid-FLUSH, asynchronously off-edge -> outputs 0 immediately, no o_done pulse, o_ready=1 in the first cycle after release.
REQ-041 Accept 8'h00 and 8'h80 -> o_sframe width is always 8 cycles, independent of the data value.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// rtl/shift_seq_ctrl_pkg.sv - shared state encoding and defaults for the serializer controller
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // One counter serves both phases, so it must hold the larger of the two lengths.
  function automatic int cnt_width(input int width, input int depth);
    int m;
    m = (width > depth) ? width : depth;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// rtl/shift_bit_counter.sv - loadable, clearable saturating down-counter for SHIFT/FLUSH timing
module shift_bit_counter #(
  parameter int CW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_zero
);

  logic [CW-1:0] count_q, count_d;

  // Saturates at zero so a late decrement can never wrap into a long count.
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_load) begin
      count_d = i_load_val;
    end else if (i_en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_zero = (count_q == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - parallel-to-serial controller feeding a falling-edge SISO register
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  input  logic             i_abort,
  output logic             o_sdata,
  output logic             o_shift_en,
  output logic             o_sframe,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = cnt_width(WIDTH, DEPTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             ready_en_q;

  logic             accept;
  logic             cnt_zero;
  logic             cnt_clr;
  logic             cnt_load;
  logic             cnt_en;
  logic [CW-1:0]    cnt_load_val;

  // Abort wins over accept, and nothing is taken until one edge after reset release.
  assign accept = ready_en_q && (state_q == ST_IDLE) && i_valid && !i_abort;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      done_q     <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ready_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (i_abort)       state_d = ST_IDLE;
        else if (cnt_zero) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter holds "cycles remaining minus one" for the current phase.
  always_comb begin
    cnt_clr      = i_abort && (state_q != ST_IDLE);
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = (state_q != ST_IDLE);
    if (accept) begin
      cnt_load     = 1'b1;
      cnt_load_val = CW'(WIDTH - 1);
    end else if ((state_q == ST_SHIFT) && cnt_zero) begin
      cnt_load     = 1'b1;
      cnt_load_val = CW'(DEPTH - 1);
    end

    data_d = data_q;
    if (cnt_clr) begin
      data_d = '0;
    end else if (accept) begin
      data_d = i_data;
    end else if (state_q == ST_SHIFT) begin
      data_d = {data_q[WIDTH-2:0], 1'b0};
    end
  end

  shift_bit_counter #(
    .CW(CW)
  ) u_bit_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (cnt_clr),
    .i_load     (cnt_load),
    .i_load_val (cnt_load_val),
    .i_en       (cnt_en),
    .o_zero     (cnt_zero)
  );

  always_comb begin
    o_ready    = ready_en_q && (state_q == ST_IDLE);
    o_busy     = (state_q != ST_IDLE);
    o_shift_en = (state_q != ST_IDLE);
    o_sframe   = (state_q == ST_SHIFT);
    o_sdata    = (state_q == ST_SHIFT) && data_q[WIDTH-1];
    o_done     = done_q;
  end

endmodule
